branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch resolution controller for the 151 core's execute stage. Accepts one conditional branch per handshake, drives the shared comparator datapath with the correct signed/unsigned mode, and registers the taken decision and target. It checks the decision against the fetch-stage prediction and sequences a fixed-length pipeline flush on mispredict.

## Interface
- `XLEN`, 32: operand, PC and immediate width.
- `FLUSH_CYCLES`, 2: cycles `flush` stays high after a mispredict handshake; legal range is 1..15.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  1  branch request valid.
- `req_ready`  out  1  controller can accept a request.
- `req_funct3`  in  3  branch funct3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
- `req_rs1`, `req_rs2`  in  XLEN  operands.
- `req_pc`, `req_imm`  in  XLEN  branch PC and sign-extended offset.
- `req_pred_taken`  in  1  fetch prediction.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  consumer accepts the result.
- `res_taken`  out  1  resolved direction.
- `res_target`  out  XLEN  next PC: `pc+imm` if taken, else `pc+4`.
- `res_mispredict`  out  1  `res_taken != pred_taken`.
- `res_illegal`  out  1  funct3 is 010 or 011.
- `res_misalign`  out  1  taken and `res_target[1:0] != 0`.
- `flush`  out  1  redirect/flush of younger stages.
- `kill`  in  1  synchronous discard from an older exception.

## Operation
- FSM states: IDLE, RESULT, FLUSH.
- IDLE: `req_ready=1`. An accepted request latches the compare outcome and target, then moves to RESULT.
- RESULT: `res_valid=1`. Outputs stay stable until `res_ready`. On the handshake:
  - mispredict=0 with a new request accepted in the same cycle: stay in RESULT with the new entry.
  - mispredict=0 with no new request: go to IDLE.
  - mispredict=1: go to FLUSH and load the flush counter with `FLUSH_CYCLES-1`.
- `req_ready` is 1 in IDLE, and in RESULT only when `res_ready && !res_mispredict_r`. It is 0 in FLUSH.
- FLUSH: `flush=1`. The counter decrements each cycle, and the state returns to IDLE after the cycle in which the counter is 0.
- `kill` forces IDLE from any state on the next edge. It drops the held result and aborts any flush. It has priority over all handshakes. A request presented in the same cycle as `kill` is not accepted (`req_ready=0` while `kill` is high).
- Compare mode: BrUn=1 for BLTU/BGEU. BNE inverts BrEq. BGE/BGEU invert BrLT.
- Illegal funct3: taken=0 and illegal=1. Mispredict is still computed from taken=0.
- Arithmetic: `pc+imm` and `pc+4` are computed modulo 2^XLEN, so wrap-around is silent.

## Timing
- Reset values: `req_ready=1`, `res_valid=0`, `res_taken=0`, `res_target=0`, `res_mispredict=0`, `res_illegal=0`, `res_misalign=0`, `flush=0`. State is IDLE and the counter is 0.
- Latency: a request accepted at edge N gives `res_valid` during cycle N+1 (one registered stage).
- Throughput: one branch per cycle when predictions are correct and `res_ready=1`.
- `flush` rises the cycle after the mispredict handshake and lasts exactly FLUSH_CYCLES cycles. `req_ready` returns the cycle after `flush` falls.
- All outputs are registered except `req_ready`, which is combinational from state, `res_ready` and `kill`.

## Configuration
- `BRANCH_CTRL_STATS_EN` defined: adds two 32-bit counters, `stat_branches` and `stat_mispredicts`, as output ports.
  - They increment on each result handshake that is not killed; `stat_mispredicts` increments only when `res_mispredict=1`.
  - They reset to 0 and wrap at 2^32.
- `BRANCH_CTRL_STATS_EN` undefined: neither the ports nor the counters exist.

## Structure
- Package `branch_pkg`: the funct3 localparams, the FSM state enum (2 bits), and the `FLUSH_CYCLES` counter width (4).
- Sub-module `branch_cmp`: a combinational XLEN comparator with inputs `RS1_data`, `RS2_data` and `BrUn`, and outputs `BrEq` and `BrLT`. It is instantiated once.
- The funct3 decode, FSM, target adders and stats counters are in the top level.

## Test plan
- Reset with `rst_n` low mid-RESULT: all outputs take their reset values immediately, and `req_ready=1` after release.
- BLT, rs1=0xFFFFFFFF, rs2=1, pred=1, pc=0x100, imm=0x20: taken=1, target=0x120, mispredict=0, `res_valid` one cycle after accept. The same operands with BLTU give taken=0, target=0x104, mispredict=1.
- Mispredict handshake with FLUSH_CYCLES=2: `flush` high for exactly 2 cycles, `req_ready` low for 3 cycles, then IDLE.
- Back-to-back: 4 correctly predicted BEQ/BNE requests with `res_ready` held 1 produce 4 results on consecutive cycles. Stalling `res_ready` for 3 cycles holds outputs stable and `req_ready` low.
- `kill` asserted during FLUSH and during RESULT: returns to IDLE next cycle, `flush` and `res_valid` drop, and the stats counters do not increment.
- funct3=010, pc=0xFFFFFFFC, imm=8: illegal=1, taken=0, target=0x00000000 (pc+4 wraps). BEQ taken with imm=2: misalign=1.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution controller: funct3 codes,
// FSM state encoding and the flush counter width.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RESULT = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

endpackage

// File: rtl/branch_cmp.sv
// Combinational XLEN comparator shared by the branch datapath.
// BrUn selects unsigned ordering for BrLT.
module branch_cmp #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] RS1_data,
  input  logic [XLEN-1:0] RS2_data,
  input  logic            BrUn,
  output logic            BrEq,
  output logic            BrLT
);

  // Equality and signed/unsigned less-than of the two operands
  always_comb begin
    BrEq = (RS1_data == RS2_data);
    if (BrUn) BrLT = (RS1_data < RS2_data);
    else      BrLT = ($signed(RS1_data) < $signed(RS2_data));
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: resolves one conditional branch per
// handshake, registers direction/target, checks the fetch prediction and
// sequences a fixed-length flush on mispredict.
// Optional macro BRANCH_CTRL_STATS_EN adds branch/mispredict counters.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_imm,
  input  logic            req_pred_taken,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_taken,
  output logic [XLEN-1:0] res_target,
  output logic            res_mispredict,
  output logic            res_illegal,
  output logic            res_misalign,
  output logic            flush,
  input  logic            kill
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;

  logic             br_un;
  logic             br_eq;
  logic             br_lt;
  logic             taken_d;
  logic             illegal_d;
  logic [XLEN-1:0]  target_d;
  logic             accept;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .RS1_data (req_rs1),
    .RS2_data (req_rs2),
    .BrUn     (br_un),
    .BrEq     (br_eq),
    .BrLT     (br_lt)
  );

  // funct3 decode: comparator mode, direction, legality and next PC
  always_comb begin
    br_un     = (req_funct3 == F3_BLTU) || (req_funct3 == F3_BGEU);
    illegal_d = 1'b0;
    taken_d   = 1'b0;
    case (req_funct3)
      F3_BEQ:           taken_d = br_eq;
      F3_BNE:           taken_d = !br_eq;
      F3_BLT, F3_BLTU:  taken_d = br_lt;
      F3_BGE, F3_BGEU:  taken_d = !br_lt;
      default:          illegal_d = 1'b1;
    endcase
    target_d = taken_d ? (req_pc + req_imm) : (req_pc + XLEN'(4));
  end

  // State register plus registered valid/flush flags and flush counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      res_valid <= 1'b0;
      flush     <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= next_state;
      res_valid <= (next_state == S_RESULT);
      flush     <= (next_state == S_FLUSH);
      if (kill)
        cnt <= '0;
      else if (state == S_RESULT && res_ready && res_mispredict)
        cnt <= CNT_W'(FLUSH_CYCLES - 1);
      else if (state == S_FLUSH && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  // Next-state logic; kill overrides every handshake
  always_comb begin
    next_state = state;
    if (kill) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (req_valid) next_state = S_RESULT;
        S_RESULT: begin
          if (res_ready) begin
            if (res_mispredict)  next_state = S_FLUSH;
            else if (req_valid)  next_state = S_RESULT;
            else                 next_state = S_IDLE;
          end
        end
        S_FLUSH:  if (cnt == '0) next_state = S_IDLE;
        default:  next_state = S_IDLE;
      endcase
    end
  end

  // Request-side ready, the only combinational output
  always_comb begin
    req_ready = 1'b0;
    if (!kill) begin
      case (state)
        S_IDLE:   req_ready = 1'b1;
        S_RESULT: req_ready = res_ready && !res_mispredict;
        default:  req_ready = 1'b0;
      endcase
    end
  end

  assign accept = req_valid && req_ready;

  // Result registers, loaded on each accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_taken      <= 1'b0;
      res_target     <= '0;
      res_mispredict <= 1'b0;
      res_illegal    <= 1'b0;
      res_misalign   <= 1'b0;
    end else if (accept) begin
      res_taken      <= taken_d;
      res_target     <= target_d;
      res_mispredict <= (taken_d != req_pred_taken);
      res_illegal    <= illegal_d;
      res_misalign   <= taken_d && (target_d[1:0] != 2'b00);
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  // Count completed result handshakes that were not killed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (res_valid && res_ready && !kill) begin
      stat_branches <= stat_branches + 32'd1;
      if (res_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
module tb_branch_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int unsigned FC   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_funct3 = '0;
  logic [XLEN-1:0] req_rs1 = '0;
  logic [XLEN-1:0] req_rs2 = '0;
  logic [XLEN-1:0] req_pc = '0;
  logic [XLEN-1:0] req_imm = '0;
  logic            req_pred_taken = 1'b0;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic            res_mispredict;
  logic            res_illegal;
  logic            res_misalign;
  logic            flush;
  logic            kill = 1'b0;
`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_funct3     (req_funct3),
    .req_rs1        (req_rs1),
    .req_rs2        (req_rs2),
    .req_pc         (req_pc),
    .req_imm        (req_imm),
    .req_pred_taken (req_pred_taken),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_taken      (res_taken),
    .res_target     (res_target),
    .res_mispredict (res_mispredict),
    .res_illegal    (res_illegal),
    .res_misalign   (res_misalign),
    .flush          (flush),
    .kill           (kill)
`ifdef BRANCH_CTRL_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a held result (or none), remaining flush cycles, stats
  bit              m_valid;
  bit              m_taken, m_mis, m_ill, m_mal;
  logic [XLEN-1:0] m_target;
  int              m_flush_left;
  logic [31:0]     m_branches, m_mispredicts;
  bit              last_ready;

  function automatic void ref_branch(input logic [2:0] f3, input logic [XLEN-1:0] a, b, pc, imm,
                                     input bit pred, output bit tk, output logic [XLEN-1:0] tgt,
                                     output bit mis, output bit ill, output bit mal);
    tk  = 1'b0;
    ill = 1'b0;
    case (f3)
      3'b000: tk = (a == b);
      3'b001: tk = (a != b);
      3'b100: tk = ($signed(a) <  $signed(b));
      3'b101: tk = ($signed(a) >= $signed(b));
      3'b110: tk = (a <  b);
      3'b111: tk = (a >= b);
      default: ill = 1'b1;
    endcase
    tgt = tk ? pc + imm : pc + 32'd4;
    mis = (tk != pred);
    mal = tk && (tgt % 4 != 0);
  endfunction

  function automatic bit model_ready();
    if (kill) return 1'b0;
    if (m_flush_left > 0) return 1'b0;
    if (!m_valid) return 1'b1;
    return res_ready && !m_mis;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_taken = 0; m_mis = 0; m_ill = 0; m_mal = 0;
    m_target = '0; m_flush_left = 0; m_branches = '0; m_mispredicts = '0;
  endtask

  task automatic model_edge(input bit rdy);
    bit acc;
    acc = req_valid && rdy;
    if (kill) begin
      m_valid = 0;
      m_flush_left = 0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else begin
      if (m_valid && res_ready) begin
        m_branches++;
        if (m_mis) begin
          m_mispredicts++;
          m_flush_left = FC;
        end
        m_valid = 0;
      end
      if (acc) begin
        ref_branch(req_funct3, req_rs1, req_rs2, req_pc, req_imm, req_pred_taken,
                   m_taken, m_target, m_mis, m_ill, m_mal);
        m_valid = 1;
      end
    end
  endtask

  // One clock: check ready before the edge, advance model, check outputs after
  task automatic step();
    bit rdy;
    @(negedge clk);
    rdy = model_ready();
    last_ready = req_ready;
    check("req_ready", req_ready, rdy);
    @(posedge clk);
    model_edge(rdy);
    #1;
    check("res_valid", res_valid, m_valid);
    check("flush", flush, m_flush_left > 0);
    if (m_valid) begin
      check("res_taken", res_taken, m_taken);
      check("res_target", res_target, m_target);
      check("res_mispredict", res_mispredict, m_mis);
      check("res_illegal", res_illegal, m_ill);
      check("res_misalign", res_misalign, m_mal);
    end
`ifdef BRANCH_CTRL_STATS_EN
    check("stat_branches", stat_branches, m_branches);
    check("stat_mispredicts", stat_mispredicts, m_mispredicts);
`endif
  endtask

  task automatic set_req(input logic [2:0] f3, input logic [XLEN-1:0] a, b, pc, imm, input bit pred);
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b;
    req_pc = pc; req_imm = imm; req_pred_taken = pred;
  endtask

  task automatic drain();
    req_valid = 1'b0; res_ready = 1'b1; kill = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b1);
    check({tag, "_res_valid"}, res_valid, 1'b0);
    check({tag, "_res_taken"}, res_taken, 1'b0);
    check({tag, "_res_target"}, res_target, '0);
    check({tag, "_res_mispredict"}, res_mispredict, 1'b0);
    check({tag, "_res_illegal"}, res_illegal, 1'b0);
    check({tag, "_res_misalign"}, res_misalign, 1'b0);
    check({tag, "_flush"}, flush, 1'b0);
`ifdef BRANCH_CTRL_STATS_EN
    check({tag, "_stat_br"}, stat_branches, '0);
    check({tag, "_stat_mp"}, stat_mispredicts, '0);
`endif
  endtask

  initial begin
    bit              tk, mis, ill, mal;
    logic [XLEN-1:0] tgt, a, b;
    logic [XLEN-1:0] snap_target;
    logic [2:0]      f3;
    int              n_flush, n_low, n_res;
    logic [31:0]     snap_br;

    model_reset();
    #12;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted while a result is held
    set_req(3'b000, 32'd5, 32'd5, 32'h40, 32'h8, 1'b1);
    step();
    check("pre_rst_valid", res_valid, 1'b1);
    req_valid = 1'b0; res_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    #1 rst_n = 1'b1;
    res_ready = 1'b1;
    step();

    // BLT signed, then BLTU back-to-back with the same operands
    set_req(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b1);
    step();
    check("blt_valid", res_valid, 1'b1);
    check("blt_taken", res_taken, 1'b1);
    check("blt_target", res_target, 32'h120);
    check("blt_mis", res_mispredict, 1'b0);
    set_req(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b1);
    res_ready = 1'b1;
    step();
    check("bltu_taken", res_taken, 1'b0);
    check("bltu_target", res_target, 32'h104);
    check("bltu_mis", res_mispredict, 1'b1);

    // Mispredict handshake -> flush sequence
    req_valid = 1'b0;
    n_flush = 0; n_low = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (flush) n_flush++;
      if (!last_ready) n_low++;
    end
    check("flush_len", n_flush, FC);
    check("ready_low_len", n_low, FC + 1);

    // Four correctly predicted BEQ/BNE back-to-back
    drain();
    n_res = 0; n_low = 0;
    for (int i = 0; i < 4; i++) begin
      f3 = (i % 2 == 0) ? 3'b000 : 3'b001;
      a  = $urandom;
      b  = (i < 2) ? a : $urandom;
      ref_branch(f3, a, b, 32'h1000 + 32'(i * 4), 32'h40, 1'b0, tk, tgt, mis, ill, mal);
      set_req(f3, a, b, 32'h1000 + 32'(i * 4), 32'h40, tk);
      step();
      if (res_valid) n_res++;
      if (!last_ready) n_low++;
    end
    check("b2b_results", n_res, 4);
    check("b2b_stalls", n_low, 0);

    // Stall res_ready for 3 cycles with a pending request
    set_req(3'b000, 32'd1, 32'd1, 32'h2000, 32'h10, 1'b1);
    res_ready = 1'b0;
    snap_target = res_target;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ready", last_ready, 1'b0);
      check("stall_target", res_target, snap_target);
      check("stall_valid", res_valid, 1'b1);
    end
    drain();

    // Kill while a mispredicted result is held
    set_req(3'b000, 32'd1, 32'd2, 32'h3000, 32'h10, 1'b1);
    step();
`ifdef BRANCH_CTRL_STATS_EN
    snap_br = stat_branches;
`else
    snap_br = '0;
`endif
    req_valid = 1'b1; res_ready = 1'b1; kill = 1'b1;
    step();
    check("kill_res_valid", res_valid, 1'b0);
    check("kill_res_flush", flush, 1'b0);
`ifdef BRANCH_CTRL_STATS_EN
    check("kill_res_stats", stat_branches, snap_br);
`endif
    kill = 1'b0; req_valid = 1'b0;
    step();

    // Kill during flush
    set_req(3'b000, 32'd1, 32'd2, 32'h3000, 32'h10, 1'b1);
    step();
    req_valid = 1'b0;
    step();
    check("pre_kill_flush", flush, 1'b1);
    kill = 1'b1;
    step();
    check("kill_flush_flush", flush, 1'b0);
    check("kill_flush_valid", res_valid, 1'b0);
    kill = 1'b0;
    step();
    check("post_kill_ready", last_ready, 1'b1);
    drain();

    // Illegal funct3 with PC wrap, then misaligned taken BEQ
    set_req(3'b010, 32'd7, 32'd7, 32'hFFFF_FFFC, 32'd8, 1'b0);
    step();
    check("ill_illegal", res_illegal, 1'b1);
    check("ill_taken", res_taken, 1'b0);
    check("ill_target", res_target, 32'h0);
    set_req(3'b000, 32'd9, 32'd9, 32'h200, 32'd2, 1'b1);
    step();
    check("mal_misalign", res_misalign, 1'b1);
    check("mal_target", res_target, 32'h202);
    drain();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      set_req(f3, a, b, $urandom, ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFC),
              1'($urandom_range(0, 1)));
      req_valid = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 4) != 0);
      kill      = ($urandom_range(0, 24) == 0);
      step();
    end
    kill = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
